// File: rtl/camera_pattern_gen_pkg.sv
// Shared types and constants for the synthetic camera source.
// Holds mode encodings, luma constants, the frame state enum and the latched config record.
package camera_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BLOB    = 2'd3
    } cam_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_BACK,
        ST_ACTIVE,
        ST_FRONT
    } frame_state_e;

    localparam logic [7:0] LUMA_BG        = 8'h10;
    localparam logic [7:0] LUMA_HI        = 8'hFF;
    localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

    typedef struct packed {
        cam_mode_e   mode;
        logic [15:0] blobX;
        logic [15:0] blobY;
        logic [7:0]  blobSize;
    } cam_cfg_t;

endpackage

// File: rtl/camera_pattern_gen_if.sv
// Config inputs and OV7670-style video outputs of the camera source.
// master is the generator side, slave is the consumer/controller side.
interface camera_pattern_gen_if;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] blobX;
    logic [15:0] blobY;
    logic [7:0]  blobSize;
    logic        href;
    logic        vsync;
    logic [7:0]  camData;
    logic        frameStart;
    logic [15:0] frameCount;

    modport master (
        input  enable, mode, blobX, blobY, blobSize,
        output href, vsync, camData, frameStart, frameCount
    );

    modport slave (
        output enable, mode, blobX, blobY, blobSize,
        input  href, vsync, camData, frameStart, frameCount
    );
endinterface

// File: rtl/camera_pattern_gen_timing.sv
// Frame timing FSM: byte/line counters and the IDLE/VSYNC/BACK/ACTIVE/FRONT sequence.
// Outputs are decodes of the registered state; the top registers them once more.
module camera_timing_gen
    import camera_gen_pkg::*;
#(
    parameter int FRAME_WIDTH     = 640,
    parameter int FRAME_HEIGHT    = 480,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_BLANK         = 144,
    parameter int VSYNC_LINES     = 3,
    parameter int V_BACK_LINES    = 17,
    parameter int V_FRONT_LINES   = 10
) (
    input  logic        pixelClock,
    input  logic        reset,
    input  logic        enable,
    output logic        href,
    output logic        vsync,
    output logic        frameLoad,
    output logic        frameBegin,
    output logic        frameEnd,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        byteIndex
);
    localparam int ACTIVE_BYTES = FRAME_WIDTH * BYTES_PER_PIXEL;
    localparam int LINE_LEN     = ACTIVE_BYTES + H_BLANK;
    localparam int BW           = $clog2(LINE_LEN + 1);
    localparam frame_state_e FIRST_STATE = (VSYNC_LINES > 0)  ? ST_VSYNC :
                                           (V_BACK_LINES > 0) ? ST_BACK  : ST_ACTIVE;

    frame_state_e  state;
    logic [BW-1:0] byteCnt;
    logic [15:0]   lineCnt;
    logic          lastByte;
    logic          lastLine;

    function automatic int linesIn(frame_state_e s);
        case (s)
            ST_VSYNC:  return VSYNC_LINES;
            ST_BACK:   return V_BACK_LINES;
            ST_ACTIVE: return FRAME_HEIGHT;
            ST_FRONT:  return V_FRONT_LINES;
            default:   return 0;
        endcase
    endfunction

    // Zero-length states are never entered; the FRONT skip is folded into frameEnd.
    function automatic frame_state_e nextAfter(frame_state_e s);
        case (s)
            ST_VSYNC:  return (V_BACK_LINES > 0) ? ST_BACK : ST_ACTIVE;
            ST_BACK:   return ST_ACTIVE;
            ST_ACTIVE: return ST_FRONT;
            default:   return ST_IDLE;
        endcase
    endfunction

    assign lastByte  = (byteCnt == BW'(LINE_LEN - 1));
    assign lastLine  = (lineCnt == 16'(linesIn(state) - 1));
    assign frameEnd  = lastByte && lastLine &&
                       (state == ST_FRONT || (state == ST_ACTIVE && V_FRONT_LINES == 0));
    assign frameLoad = enable && (state == ST_IDLE || frameEnd);

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            byteCnt    <= '0;
            lineCnt    <= '0;
            frameBegin <= 1'b0;
        end else begin
            frameBegin <= frameLoad;
            if (frameLoad) begin
                state   <= FIRST_STATE;
                byteCnt <= '0;
                lineCnt <= '0;
            end else if (state != ST_IDLE) begin
                if (!lastByte) begin
                    byteCnt <= byteCnt + BW'(1);
                end else begin
                    byteCnt <= '0;
                    if (!lastLine) begin
                        lineCnt <= lineCnt + 16'd1;
                    end else begin
                        lineCnt <= '0;
                        state   <= frameEnd ? ST_IDLE : nextAfter(state);
                    end
                end
            end
        end
    end

    assign href      = (state == ST_ACTIVE) && (byteCnt < BW'(ACTIVE_BYTES));
    assign vsync     = (state == ST_VSYNC);
    assign x         = (BYTES_PER_PIXEL == 2) ? 16'(byteCnt >> 1) : 16'(byteCnt);
    assign byteIndex = (BYTES_PER_PIXEL == 2) ? byteCnt[0] : 1'b0;
    assign y         = lineCnt;

endmodule

// File: rtl/camera_pattern_gen.sv
// Synthetic OV7670-style camera source: latched config, pattern luma and registered outputs.
// Optional build macro CAMGEN_FRAME_STAMP_EN stamps frameCount into pixels 0/1 of line 0.
module camera_pattern_gen
    import camera_gen_pkg::*;
#(
    parameter int FRAME_WIDTH     = 640,
    parameter int FRAME_HEIGHT    = 480,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_BLANK         = 144,
    parameter int VSYNC_LINES     = 3,
    parameter int V_BACK_LINES    = 17,
    parameter int V_FRONT_LINES   = 10
) (
    input logic pixelClock,
    input logic reset,
    camera_pattern_gen_if.master bus
);
    logic        tHref, tVsync, tLoad, tBegin, tEnd, tByteIndex;
    logic [15:0] tX, tY;
    cam_cfg_t    cfg;
    logic [7:0]  luma;
    logic        inX, inY;
    logic        hrefR, vsyncR, frameStartR;
    logic [7:0]  camDataR;
    logic [15:0] frameCountR;

    camera_timing_gen #(
        .FRAME_WIDTH    (FRAME_WIDTH),
        .FRAME_HEIGHT   (FRAME_HEIGHT),
        .BYTES_PER_PIXEL(BYTES_PER_PIXEL),
        .H_BLANK        (H_BLANK),
        .VSYNC_LINES    (VSYNC_LINES),
        .V_BACK_LINES   (V_BACK_LINES),
        .V_FRONT_LINES  (V_FRONT_LINES)
    ) timing (
        .pixelClock(pixelClock),
        .reset     (reset),
        .enable    (bus.enable),
        .href      (tHref),
        .vsync     (tVsync),
        .frameLoad (tLoad),
        .frameBegin(tBegin),
        .frameEnd  (tEnd),
        .x         (tX),
        .y         (tY),
        .byteIndex (tByteIndex)
    );

    // 17-bit bounds so blobX+blobSize near 0xFFFF cannot wrap into the frame.
    assign inX = ({1'b0, tX} >= {1'b0, cfg.blobX}) &&
                 ({1'b0, tX} <  {1'b0, cfg.blobX} + {9'd0, cfg.blobSize});
    assign inY = ({1'b0, tY} >= {1'b0, cfg.blobY}) &&
                 ({1'b0, tY} <  {1'b0, cfg.blobY} + {9'd0, cfg.blobSize});

    always_comb begin
        luma = LUMA_BG;
        case (cfg.mode)
            MODE_SOLID:   luma = LUMA_BG;
            MODE_RAMP:    luma = tX[7:0];
            MODE_CHECKER: luma = (tX[3] ^ tY[3]) ? LUMA_HI : 8'h00;
            MODE_BLOB:    luma = (inX && inY) ? LUMA_HI : LUMA_BG;
        endcase
`ifdef CAMGEN_FRAME_STAMP_EN
        if (tY == 16'd0 && tX == 16'd0) luma = frameCountR[15:8];
        if (tY == 16'd0 && tX == 16'd1) luma = frameCountR[7:0];
`endif
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            hrefR       <= 1'b0;
            vsyncR      <= 1'b0;
            frameStartR <= 1'b0;
            camDataR    <= 8'h00;
            frameCountR <= 16'h0000;
            cfg         <= '0;
        end else begin
            hrefR       <= tHref;
            vsyncR      <= tVsync;
            frameStartR <= tBegin && tVsync;
            camDataR    <= !tHref ? 8'h00 : (tByteIndex ? CHROMA_NEUTRAL : luma);
            if (tEnd) frameCountR <= frameCountR + 16'd1;
            // Config is captured as the next frame is launched, so it is stable for the whole frame.
            if (tLoad) begin
                cfg <= '{mode:     cam_mode_e'(bus.mode),
                         blobX:    bus.blobX,
                         blobY:    bus.blobY,
                         blobSize: bus.blobSize};
            end
        end
    end

    assign bus.href       = hrefR;
    assign bus.vsync      = vsyncR;
    assign bus.camData    = camDataR;
    assign bus.frameStart = frameStartR;
    assign bus.frameCount = frameCountR;

endmodule

// File: tb/tb_camera_pattern_gen.sv
// Directed bench for camera_pattern_gen on an 8x4, 2-byte, 20-clock-line, 140-clock frame.
module tb_camera_pattern_gen;
    localparam int FRAME = 140;
`ifdef CAMGEN_FRAME_STAMP_EN
    localparam bit STAMP = 1'b1;
`else
    localparam bit STAMP = 1'b0;
`endif

    logic pixelClock;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    logic       capHref [0:FRAME];
    logic       capVs   [0:FRAME];
    logic       capFs   [0:FRAME];
    logic [7:0] capData [0:FRAME];
    logic [15:0] capFc  [0:FRAME];

    camera_pattern_gen_if bus();

    camera_pattern_gen #(
        .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .BYTES_PER_PIXEL(2), .H_BLANK(4),
        .VSYNC_LINES(1), .V_BACK_LINES(1), .V_FRONT_LINES(1)
    ) dut (
        .pixelClock(pixelClock),
        .reset     (reset),
        .bus       (bus)
    );

    initial pixelClock = 1'b0;
    always #5 pixelClock = ~pixelClock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected byte at offset o of active line y, given an 8-entry luma table.
    function automatic logic [7:0] expByte(input logic [7:0] lum [8], input int o, input int y,
                                           input logic [15:0] fc);
        logic [7:0] l;
        if (o >= 16) return 8'h00;
        if ((o % 2) == 1) return 8'h80;
        l = lum[o / 2];
        if (STAMP && y == 0 && o == 0) l = fc[15:8];
        if (STAMP && y == 0 && o == 2) l = fc[7:0];
        return l;
    endfunction

    // Records 141 samples starting at a frameStart; idx 140 is the following frame's first cycle.
    task automatic capture(input bit fresh, input int switchAt, input logic [1:0] swMode,
                           input logic swEn);
        int n = 0;
        if (fresh || bus.frameStart !== 1'b1) begin
            do begin
                @(posedge pixelClock); #1; n++;
            end while (bus.frameStart !== 1'b1 && n < 400);
            checks++;
            if (bus.frameStart !== 1'b1) begin
                failures++;
                $display("FAIL frame_start_wait: got frameStart=%b want 1 within 400 clocks", bus.frameStart);
            end
        end
        for (int i = 0; i <= FRAME; i++) begin
            if (i > 0) begin @(posedge pixelClock); #1; end
            capHref[i] = bus.href;
            capVs[i]   = bus.vsync;
            capFs[i]   = bus.frameStart;
            capData[i] = bus.camData;
            capFc[i]   = bus.frameCount;
            if (i == switchAt) begin
                bus.mode   = swMode;
                bus.enable = swEn;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge pixelClock);
        #1;
        checks++; if (bus.href !== 1'b0) begin failures++; $display("FAIL reset_href: got %b want 0", bus.href); end
        checks++; if (bus.vsync !== 1'b0) begin failures++; $display("FAIL reset_vsync: got %b want 0", bus.vsync); end
        checks++; if (bus.camData !== 8'h00) begin failures++; $display("FAIL reset_camData: got %02h want 00", bus.camData); end
        checks++; if (bus.frameStart !== 1'b0) begin failures++; $display("FAIL reset_frameStart: got %b want 0", bus.frameStart); end
        checks++; if (bus.frameCount !== 16'h0000) begin failures++; $display("FAIL reset_frameCount: got %04h want 0000", bus.frameCount); end
        reset = 1'b0;
        repeat (5) @(posedge pixelClock);
        #1;
        checks++;
        if ({bus.href, bus.vsync} !== 2'b00) begin
            failures++; $display("FAIL idle_no_enable: got href/vsync=%b%b want 00", bus.href, bus.vsync);
        end
    endtask

    task automatic test_timing();
        bus.mode   = 2'd1;
        bus.enable = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            int bv = -1, bh = -1, bs = -1;
            logic ev, eh, es;
            capture(f == 1, -1, 2'd1, 1'b1);
            for (int i = 0; i <= FRAME; i++) begin
                ev = (i < 20) || (i == FRAME);
                eh = (i >= 40) && (i < 120) && (((i - 40) % 20) < 16);
                es = (i == 0) || (i == FRAME);
                if (bv < 0 && capVs[i] !== ev) bv = i;
                if (bh < 0 && capHref[i] !== eh) bh = i;
                if (bs < 0 && capFs[i] !== es) bs = i;
            end
            checks++;
            if (bv >= 0) begin failures++; $display("FAIL vsync_pattern f%0d cycle %0d: got %b want %b", f, bv, capVs[bv], !capVs[bv]); end
            checks++;
            if (bh >= 0) begin failures++; $display("FAIL href_pattern f%0d cycle %0d: got %b want %b", f, bh, capHref[bh], !capHref[bh]); end
            checks++;
            if (bs >= 0) begin failures++; $display("FAIL frameStart_period f%0d cycle %0d: got %b want %b", f, bs, capFs[bs], !capFs[bs]); end
            checks++;
            if (capFc[FRAME] !== 16'(f)) begin failures++; $display("FAIL frameCount_f%0d: got %0d want %0d", f, capFc[FRAME], f); end
        end
    endtask

    task automatic test_ramp();
        logic [7:0] lum [8];
        int bad = -1;
        lum = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        capture(1'b0, -1, 2'd1, 1'b1);
        for (int y = 0; y < 4; y++) begin
            int b = -1;
            logic [7:0] want = 8'h00, got = 8'h00;
            for (int o = 0; o < 20; o++) begin
                logic [7:0] e;
                e = expByte(lum, o, y, capFc[0]);
                if (b < 0 && capData[40 + 20*y + o] !== e) begin b = o; want = e; got = capData[40 + 20*y + o]; end
            end
            checks++;
            if (b >= 0) begin failures++; $display("FAIL ramp_line%0d byte %0d: got %02h want %02h", y, b, got, want); end
        end
        for (int i = 0; i < FRAME; i++)
            if (bad < 0 && (i < 40 || i >= 120) && capData[i] !== 8'h00) bad = i;
        checks++;
        if (bad >= 0) begin failures++; $display("FAIL blank_data cycle %0d: got %02h want 00", bad, capData[bad]); end
    endtask

    task automatic test_blob();
        logic [7:0] lumIn [8];
        logic [7:0] lumBg [8];
        logic [7:0] lumClip [8];
        lumIn   = '{8'h10, 8'h10, 8'hFF, 8'hFF, 8'h10, 8'h10, 8'h10, 8'h10};
        lumBg   = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
        lumClip = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'hFF};
        bus.mode = 2'd3; bus.blobX = 16'd2; bus.blobY = 16'd1; bus.blobSize = 8'd2;
        capture(1'b1, -1, 2'd3, 1'b1);
        for (int y = 0; y < 4; y++) begin
            int b = -1;
            logic [7:0] want = 8'h00, got = 8'h00;
            for (int o = 0; o < 20; o++) begin
                logic [7:0] e;
                e = (y == 1 || y == 2) ? expByte(lumIn, o, y, capFc[0]) : expByte(lumBg, o, y, capFc[0]);
                if (b < 0 && capData[40 + 20*y + o] !== e) begin b = o; want = e; got = capData[40 + 20*y + o]; end
            end
            checks++;
            if (b >= 0) begin failures++; $display("FAIL blob_line%0d byte %0d: got %02h want %02h", y, b, got, want); end
        end
        bus.blobX = 16'd7; bus.blobSize = 8'd4;
        capture(1'b1, -1, 2'd3, 1'b1);
        for (int y = 0; y < 2; y++) begin
            int b = -1;
            logic [7:0] want = 8'h00, got = 8'h00;
            for (int o = 0; o < 20; o++) begin
                logic [7:0] e;
                e = (y == 1) ? expByte(lumClip, o, y, capFc[0]) : expByte(lumBg, o, y, capFc[0]);
                if (b < 0 && capData[40 + 20*y + o] !== e) begin b = o; want = e; got = capData[40 + 20*y + o]; end
            end
            checks++;
            if (b >= 0) begin failures++; $display("FAIL blob_clip_line%0d byte %0d: got %02h want %02h", y, b, got, want); end
        end
    endtask

    task automatic test_config_latch();
        logic [7:0] lumRamp [8];
        logic [7:0] lumZero [8];
        lumRamp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        lumZero = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        bus.mode = 2'd1;
        for (int f = 0; f < 2; f++) begin
            capture(f == 0, (f == 0) ? 70 : -1, 2'd2, 1'b1);
            for (int y = 0; y < 4; y++) begin
                int b = -1;
                logic [7:0] want = 8'h00, got = 8'h00;
                for (int o = 0; o < 20; o++) begin
                    logic [7:0] e;
                    e = (f == 0) ? expByte(lumRamp, o, y, capFc[0]) : expByte(lumZero, o, y, capFc[0]);
                    if (b < 0 && capData[40 + 20*y + o] !== e) begin b = o; want = e; got = capData[40 + 20*y + o]; end
                end
                checks++;
                if (b >= 0) begin failures++; $display("FAIL latch_f%0d_line%0d byte %0d: got %02h want %02h", f, y, b, got, want); end
            end
        end
    endtask

    task automatic test_stop();
        int hcnt = 0;
        int stray = 0;
        capture(1'b1, 85, 2'd2, 1'b0);
        for (int i = 0; i < FRAME; i++) if (capHref[i] === 1'b1) hcnt++;
        checks++;
        if (hcnt != 64) begin failures++; $display("FAIL stop_frame_completes: got %0d href clocks want 64", hcnt); end
        checks++;
        if (capVs[FRAME] !== 1'b0 || capFs[FRAME] !== 1'b0) begin
            failures++; $display("FAIL stop_no_restart: got vsync=%b frameStart=%b want 0 0", capVs[FRAME], capFs[FRAME]);
        end
        repeat (300) begin
            @(posedge pixelClock); #1;
            if (bus.href !== 1'b0 || bus.vsync !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL stop_idle: got %0d active clocks want 0", stray); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit found = 1'b0;
        bus.mode = 2'd1;
        bus.enable = 1'b1;
        while (bus.frameStart !== 1'b1 && n < 10) begin @(posedge pixelClock); #1; n++; end
        checks++;
        if (bus.frameStart !== 1'b1) begin failures++; $display("FAIL restart_wait: got frameStart=%b want 1", bus.frameStart); end
        repeat (44) begin @(posedge pixelClock); #1; end
        checks++;
        if (bus.href !== 1'b1 || bus.camData !== 8'h02) begin
            failures++; $display("FAIL pre_reset_pixel: got href=%b data=%02h want 1 02", bus.href, bus.camData);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.href !== 1'b0) begin failures++; $display("FAIL midreset_href: got %b want 0", bus.href); end
        checks++; if (bus.vsync !== 1'b0) begin failures++; $display("FAIL midreset_vsync: got %b want 0", bus.vsync); end
        checks++; if (bus.camData !== 8'h00) begin failures++; $display("FAIL midreset_camData: got %02h want 00", bus.camData); end
        checks++; if (bus.frameStart !== 1'b0) begin failures++; $display("FAIL midreset_frameStart: got %b want 0", bus.frameStart); end
        checks++; if (bus.frameCount !== 16'h0000) begin failures++; $display("FAIL midreset_frameCount: got %04h want 0000", bus.frameCount); end
        repeat (2) @(posedge pixelClock);
        #1 reset = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            if (!found) begin
                @(posedge pixelClock); #1;
                if (bus.vsync === 1'b1) found = 1'b1;
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL vsync_after_reset: got vsync=%b want 1 within 2 clocks", bus.vsync); end
    endtask

    task automatic test_stamp();
        int n = 0;
        logic [7:0] got [4];
        logic [7:0] want [4];
        want = '{8'h00, 8'h80, (STAMP ? 8'h05 : 8'h01), 8'h80};
        while (!(bus.frameStart === 1'b1 && bus.frameCount === 16'd5) && n < 1500) begin
            @(posedge pixelClock); #1; n++;
        end
        checks++;
        if (bus.frameStart !== 1'b1 || bus.frameCount !== 16'd5) begin
            failures++; $display("FAIL stamp_frame_wait: got frameCount=%0d want 5 at frameStart", bus.frameCount);
        end
        repeat (40) begin @(posedge pixelClock); #1; end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge pixelClock); #1; end
            got[k] = bus.camData;
        end
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL stamp_line0: got %02h %02h %02h %02h want %02h %02h %02h %02h",
                     got[0], got[1], got[2], got[3], want[0], want[1], want[2], want[3]);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.mode     = 2'd1;
        bus.blobX    = 16'd0;
        bus.blobY    = 16'd0;
        bus.blobSize = 8'd0;
        test_reset();
        test_timing();
        test_ramp();
        test_blob();
        test_config_latch();
        test_stop();
        test_reset_mid();
        test_stamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/camera_pattern_gen.md
Name: camera_pattern_gen

Overview:
Parametrised synthetic camera source emitting OV7670-style href/vsync/camData streams with configurable resolution, blanking and pixel format. Generates selectable test patterns, including a movable bright square that serves as a marker stand-in for blob-detection tests. It drives the pipeline input in simulation benches and can also drive it on hardware for bring-up without a sensor. It replaces the fixed-geometry fake camera.

Parameters:
FRAME_WIDTH, 640, active pixels per line
FRAME_HEIGHT, 480, active lines per frame
BYTES_PER_PIXEL, 2, bytes per pixel on camData (1 or 2)
H_BLANK, 144, href-low clocks after each line's active bytes
VSYNC_LINES, 3, line periods with vsync high
V_BACK_LINES, 17, idle line periods between vsync low and the first active line
V_FRONT_LINES, 10, idle line periods after the last active line

Ports:
pixelClock  in  1  byte clock; all logic on its rising edge
reset  in  1  asynchronous, active-high
enable  in  1  run request; sampled at frame boundaries
mode  in  2  pattern select: 0 solid, 1 ramp, 2 checker, 3 blob
blobX  in  16  blob left column, in pixels
blobY  in  16  blob top row, in lines
blobSize  in  8  blob edge length, in pixels; 0 means no blob
href  out  1  line-valid
vsync  out  1  frame sync, high during the vsync lines
camData  out  8  pixel byte
frameStart  out  1  one-cycle pulse in the first cycle of vsync high
frameCount  out  16  count of completed frames, wraps

Behaviour:
- Reset: href=0, vsync=0, camData=0, frameStart=0, frameCount=0, state IDLE. Reset mid-frame aborts the frame immediately with no partial completion.
- LINE_LEN = FRAME_WIDTH*BYTES_PER_PIXEL + H_BLANK clocks. Every line period, blank or active, is exactly LINE_LEN clocks.
- States: IDLE -> VSYNC (VSYNC_LINES lines) -> BACK (V_BACK_LINES) -> ACTIVE (FRAME_HEIGHT) -> FRONT (V_FRONT_LINES) -> VSYNC if enable=1, else IDLE.
- IDLE -> VSYNC occurs in the cycle after enable is seen high.
- States whose line count is 0 are skipped.
- enable deasserted mid-frame: the current frame completes, then the block enters IDLE.
- mode, blobX, blobY and blobSize are latched on entry to VSYNC. Changes mid-frame have no effect until the next frame.
- Outputs are registered. In ACTIVE, href is high for the first FRAME_WIDTH*BYTES_PER_PIXEL clocks of each line, then low for H_BLANK clocks. href is low in all other states.
- camData is 0x00 whenever href=0.
- Pixel (x, y): x in 0..FRAME_WIDTH-1, y in 0..FRAME_HEIGHT-1.
  - BYTES_PER_PIXEL=1: byte = luma L.
  - BYTES_PER_PIXEL=2: bytes are L then 0x80 (Y, then neutral chroma).
- Luma by mode:
  - 0 solid: L=0x10.
  - 1 ramp: L=x[7:0], wraps every 256 columns.
  - 2 checker: L=0xFF if x[3]^y[3], else 0x00.
  - 3 blob: L=0xFF when blobX<=x<blobX+blobSize and blobY<=y<blobY+blobSize, else 0x10. Bounds are compared in 17-bit arithmetic, so there is no wrap. Parts of the blob beyond the frame edge are clipped.
- frameStart pulses in the same cycle that vsync rises.
- frameCount increments by 1 in the last clock of FRONT, wrapping from 0xFFFF to 0x0000.

Optional Feature:
CAMGEN_FRAME_STAMP_EN
- Defined: on active line 0, the luma of pixel 0 is frameCount[15:8] and the luma of pixel 1 is frameCount[7:0]. This overrides the pattern and lets checkers detect dropped frames.
- Undefined: no stamp; the pattern is unmodified everywhere.

Decomposition:
- Package camera_gen_pkg holds:
  - mode encodings MODE_SOLID, MODE_RAMP, MODE_CHECKER, MODE_BLOB
  - luma constants LUMA_BG=0x10, LUMA_HI=0xFF, CHROMA_NEUTRAL=0x80
  - the frame state enum
- Sub-module camera_timing_gen owns the byte, line and state counters and produces href, vsync, x, y and byteIndex.
- The top level holds the latched config, the pattern function and the output registers.

Test Plan:
Common configuration: FRAME_WIDTH=8, FRAME_HEIGHT=4, BPP=2, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, giving LINE_LEN=20 and a 140-clock frame.
1. Timing, with enable held high:
   - vsync high for exactly 20 clocks; frames repeat every 140 clocks.
   - Per frame: 4 href pulses of 16 clocks, separated by 4 low clocks.
   - frameStart coincides with vsync rising; frameCount reaches 3 after 3 frames.
2. Ramp, mode=1: each line's bytes are 00 80 01 80 … 07 80, and camData=0 whenever href=0.
3. Blob: mode=3, blobX=2, blobY=1, blobSize=2.
   - Lines 1–2: luma = 10 10 FF FF 10 10 10 10.
   - Lines 0 and 3: all 0x10.
   - Edge clip: blobX=7, blobSize=4 gives luma FF only at x=7.
4. Config latch: switch mode 1→2 mid-ACTIVE. The current frame stays ramp; the next frame is checker, with L=0x00 throughout because x<8 and y<4.
5. Stop and reset:
   - enable dropped during line 2: the frame finishes and href and vsync then stay 0.
   - Reset asserted mid-line: all outputs are 0 in the same cycle.
   - After reset release with enable high, the first vsync rises within 2 clocks.
6. With CAMGEN_FRAME_STAMP_EN defined, in frame N (frameCount=N=5): line 0 begins 00 80 05 80.
